sdspi_bus_arbiter: RTL and testbench

SDSPI_BUS_ARBITER -- requirements
Module: sdspi_bus_arbiter

---
 rtl/sdspi_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_sdspi_bus_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdspi_bus_arbiter.sv
// Shares one SD card between several SPI masters. Round-robin grant with an
// idle-bus guard interval before every grant and after every release.
module sdspi_bus_arbiter #(
  parameter int N_MASTERS    = 2,
  parameter int GUARD_CYCLES = 16,
  parameter int CNT_W        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MASTERS-1:0]         req,
  input  logic [N_MASTERS-1:0]         cs_m,
  input  logic [N_MASTERS-1:0]         sclk_m,
  input  logic [N_MASTERS-1:0]         mosi_m,
  input  logic                         force_en,
  input  logic [$clog2(N_MASTERS)-1:0] force_sel,
  output logic [N_MASTERS-1:0]         grant,
  output logic [$clog2(N_MASTERS)-1:0] owner,
  output logic                         busy,
  output logic                         cs,
  output logic                         sclk,
  output logic                         mosi,
  output logic [CNT_W-1:0]             handovers
);

  localparam int SEL_W = $clog2(N_MASTERS);
  localparam logic [7:0] GUARD_INIT = 8'(GUARD_CYCLES);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_MASTERS - 1);

  typedef enum logic [1:0] {IDLE, GUARD, OWNED, RELEASE} state_e;

  state_e                 state_q, state_d;
  logic [SEL_W-1:0]       owner_q, owner_d;
  logic [SEL_W-1:0]       cand_q, cand_d;
  logic [N_MASTERS-1:0]   grant_q, grant_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [CNT_W-1:0]       handovers_q, handovers_d;
  logic                   cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d;

  logic [N_MASTERS-1:0]   elig;
  logic [SEL_W-1:0]       pick, probe;
  logic                   pick_vld;

  // An out-of-range forced index leaves nobody eligible.
  always_comb begin : eligibility
    elig = '0;
    if (!force_en)
      elig = req;
    else if (32'(force_sel) < N_MASTERS)
      elig[force_sel] = req[force_sel];
  end

  // Search starts just after the last owner; reset owner is the top index,
  // so the first search after reset starts at master 0.
  always_comb begin : rr_search
    pick     = '0;
    pick_vld = 1'b0;
    probe    = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      probe = SEL_W'((int'(owner_q) + 1 + i) % N_MASTERS);
      if (!pick_vld && elig[probe]) begin
        pick     = probe;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin : next_state
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d     = state_q;
    owner_d     = owner_q;
    cand_d      = cand_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    handovers_d = handovers_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          cand_d  = pick;
          cnt_d   = GUARD_INIT;
          state_d = GUARD;
        end
      end
      GUARD: begin
        if (!req[cand_q]) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q <= 8'd1) begin
          cnt_d          = '0;
          grant_d        = '0;
          grant_d[cand_q] = 1'b1;
          owner_d        = cand_q;
          handovers_d    = handovers_q + CNT_W'(1);
          state_d        = OWNED;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      OWNED: begin
        if (!req[owner_q]) begin
          grant_d = '0;
          cnt_d   = GUARD_INIT;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (cnt_q <= 8'd1) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered against the next state, so they switch on
    // the same edge as grant and trail the owner's pins by one clock.
    if (state_d == OWNED) begin
      cs_d   = cs_m[owner_d];
      sclk_d = sclk_m[owner_d];
      mosi_d = mosi_m[owner_d];
    end else begin
      cs_d   = 1'b1;
      sclk_d = 1'b0;
      mosi_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= LAST_IDX;
      cand_q      <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      handovers_q <= '0;
      cs_q        <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cand_q      <= cand_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      handovers_q <= handovers_d;
      cs_q        <= cs_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
    end
  end

  assign grant     = grant_q;
  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);
  assign cs        = cs_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign handovers = handovers_q;

endmodule

// File: tb/tb_sdspi_bus_arbiter.sv
// Directed bench for sdspi_bus_arbiter: main instance N=2/GUARD=16 and a
// small-counter instance (GUARD=1, CNT_W=4) for counter wrap.
module tb_sdspi_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, cs_m, sclk_m, mosi_m;
  logic       force_en;
  logic [0:0] force_sel;
  logic [1:0] grant;
  logic [0:0] owner;
  logic       busy, cs, sclk, mosi;
  logic [31:0] handovers;

  logic [1:0] req_w, grant_w;
  logic [0:0] owner_w;
  logic       busy_w, cs_w, sclk_w, mosi_w;
  logic [3:0] handovers_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdspi_bus_arbiter #(.N_MASTERS(2), .GUARD_CYCLES(16), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .req(req), .cs_m(cs_m), .sclk_m(sclk_m), .mosi_m(mosi_m),
    .force_en(force_en), .force_sel(force_sel), .grant(grant), .owner(owner),
    .busy(busy), .cs(cs), .sclk(sclk), .mosi(mosi), .handovers(handovers)
  );

  sdspi_bus_arbiter #(.N_MASTERS(2), .GUARD_CYCLES(1), .CNT_W(4)) u_wrap (
    .clk(clk), .rst(rst), .req(req_w), .cs_m(2'b11), .sclk_m(2'b00), .mosi_m(2'b11),
    .force_en(1'b0), .force_sel(1'b0), .grant(grant_w), .owner(owner_w),
    .busy(busy_w), .cs(cs_w), .sclk(sclk_w), .mosi(mosi_w), .handovers(handovers_w)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req       = 2'b00;
    cs_m      = 2'b11;
    sclk_m    = 2'b00;
    mosi_m    = 2'b11;
    force_en  = 1'b0;
    force_sel = 1'b0;
    req_w     = 2'b00;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (grant !== 2'b00 || owner !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: grant=%b owner=%b busy=%b, want 00 1 0", grant, owner, busy);
    end
    n_checks++;
    if ({cs, sclk, mosi} !== 3'b101 || handovers !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_bus: cs/sclk/mosi=%b handovers=%0d, want 101 0", {cs, sclk, mosi}, handovers);
    end
    n_checks++;
    if (handovers_w !== 4'd0 || grant_w !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_wrap_inst: handovers=%0d grant=%b, want 0 00", handovers_w, grant_w);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_grant_latency;
    logic [2:0] pats [4];
    pats = '{3'b010, 3'b001, 3'b111, 3'b000};
    req = 2'b01;
    for (int t = 1; t <= 17; t++) begin
      tick();
      if (t == 1) begin
        n_checks++;
        if (busy !== 1'b1 || grant !== 2'b00) begin
          n_fail++;
          $display("FAIL guard_entry: busy=%b grant=%b, want 1 00", busy, grant);
        end
      end
      if (t == 16) begin
        n_checks++;
        if (grant !== 2'b00) begin
          n_fail++;
          $display("FAIL grant_early: grant=%b at cycle 16, want 00", grant);
        end
      end
    end
    n_checks++;
    if (grant !== 2'b01 || owner !== 1'b0 || handovers !== 32'd1) begin
      n_fail++;
      $display("FAIL grant_lat: grant=%b owner=%b handovers=%0d at cycle 17, want 01 0 1", grant, owner, handovers);
    end
    // Master 1 drives the opposite levels; only master 0 may reach the card.
    for (int i = 0; i < 4; i++) begin
      cs_m   = {~pats[i][2], pats[i][2]};
      sclk_m = {~pats[i][1], pats[i][1]};
      mosi_m = {~pats[i][0], pats[i][0]};
      n_checks++;
      if ((i > 0) && ({cs, sclk, mosi} !== pats[i-1])) begin
        n_fail++;
        $display("FAIL follow_hold[%0d]: bus=%b before edge, want %b", i, {cs, sclk, mosi}, pats[i-1]);
      end
      tick();
      n_checks++;
      if ({cs, sclk, mosi} !== pats[i]) begin
        n_fail++;
        $display("FAIL follow[%0d]: bus=%b, want %b", i, {cs, sclk, mosi}, pats[i]);
      end
    end
    cs_m = 2'b00; sclk_m = 2'b11; mosi_m = 2'b00;
    req = 2'b00;
    tick();
    n_checks++;
    if (grant !== 2'b00 || busy !== 1'b1 || {cs, sclk, mosi} !== 3'b101) begin
      n_fail++;
      $display("FAIL release_edge: grant=%b busy=%b bus=%b, want 00 1 101", grant, busy, {cs, sclk, mosi});
    end
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (t == 15) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL release_len: busy=%b at release cycle 15, want 1", busy);
        end
      end
    end
    n_checks++;
    if (busy !== 1'b0 || {cs, sclk, mosi} !== 3'b101) begin
      n_fail++;
      $display("FAIL release_end: busy=%b bus=%b, want 0 101", busy, {cs, sclk, mosi});
    end
    idle_inputs();
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_g;
    int lat;
    do_reset();
    req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      lat   = (k == 0) ? 17 : 33;
      for (int t = 1; t <= lat; t++) begin
        tick();
        if (t < lat) begin
          n_checks++;
          if (grant !== 2'b00 || {cs, sclk, mosi} !== 3'b101) begin
            n_fail++;
            $display("FAIL rr_gap[%0d] t=%0d: grant=%b bus=%b, want 00 101", k, t, grant, {cs, sclk, mosi});
          end
        end
      end
      n_checks++;
      if (grant !== exp_g || handovers !== 32'(k + 1)) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: grant=%b handovers=%0d, want %b %0d", k, grant, handovers, exp_g, k + 1);
      end
      req = 2'b11 & ~exp_g;
      tick();
      n_checks++;
      if (grant !== 2'b00) begin
        n_fail++;
        $display("FAIL rr_drop[%0d]: grant=%b, want 00", k, grant);
      end
      req = 2'b11;
    end
    idle_inputs();
  endtask

  task automatic test_guard_abort;
    do_reset();
    req = 2'b10;
    repeat (5) tick();
    n_checks++;
    if (busy !== 1'b1 || grant !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_guard: busy=%b grant=%b, want 1 00", busy, grant);
    end
    req = 2'b00;
    tick();
    n_checks++;
    if (busy !== 1'b0 || grant !== 2'b00 || handovers !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b grant=%b handovers=%0d, want 0 00 0", busy, grant, handovers);
    end
    repeat (20) tick();
    n_checks++;
    if (grant !== 2'b00 || handovers !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_late: grant=%b handovers=%0d, want 00 0", grant, handovers);
    end
  endtask

  task automatic test_force;
    do_reset();
    force_en  = 1'b1;
    force_sel = 1'b1;
    req       = 2'b11;
    for (int t = 1; t <= 17; t++) begin
      tick();
      n_checks++;
      if (grant === 2'b01) begin
        n_fail++;
        $display("FAIL force_m0 t=%0d: grant=%b, want not 01", t, grant);
      end
    end
    n_checks++;
    if (grant !== 2'b10 || owner !== 1'b1) begin
      n_fail++;
      $display("FAIL force_grant: grant=%b owner=%b, want 10 1", grant, owner);
    end
    force_sel = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (grant !== 2'b10) begin
      n_fail++;
      $display("FAIL force_nopreempt: grant=%b, want 10", grant);
    end
    force_sel = 1'b1;
    req = 2'b01;
    tick();
    req = 2'b11;
    for (int t = 1; t <= 33; t++) begin
      tick();
      n_checks++;
      if (grant === 2'b01) begin
        n_fail++;
        $display("FAIL force_m0_again t=%0d: grant=%b, want not 01", t, grant);
      end
    end
    n_checks++;
    if (grant !== 2'b10 || handovers !== 32'd2) begin
      n_fail++;
      $display("FAIL force_regrant: grant=%b handovers=%0d, want 10 2", grant, handovers);
    end
    force_en = 1'b0;
    req = 2'b01;
    tick();
    repeat (33) tick();
    n_checks++;
    if (grant !== 2'b01 || owner !== 1'b0) begin
      n_fail++;
      $display("FAIL force_off: grant=%b owner=%b, want 01 0", grant, owner);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset;
    do_reset();
    req = 2'b01;
    repeat (17) tick();
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("FAIL ar_setup: grant=%b, want 01", grant);
    end
    cs_m = 2'b10; sclk_m = 2'b01; mosi_m = 2'b10;
    tick();
    n_checks++;
    if ({cs, sclk, mosi} !== 3'b010) begin
      n_fail++;
      $display("FAIL ar_owned_bus: bus=%b, want 010", {cs, sclk, mosi});
    end
    #2;
    sclk_m = 2'b00;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({cs, sclk, mosi} !== 3'b101 || grant !== 2'b00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_immediate: bus=%b grant=%b busy=%b, want 101 00 0", {cs, sclk, mosi}, grant, busy);
    end
    sclk_m = 2'b01;
    #1;
    n_checks++;
    if (sclk !== 1'b0 || owner !== 1'b1 || handovers !== 32'd0) begin
      n_fail++;
      $display("FAIL ar_hold: sclk=%b owner=%b handovers=%0d, want 0 1 0", sclk, owner, handovers);
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_wrap;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      req_w = 2'b01;
      for (int c = 0; c < 10 && grant_w !== 2'b01; c++) tick();
      n_checks++;
      if (grant_w !== 2'b01) begin
        n_fail++;
        $display("FAIL wrap_grant[%0d]: grant=%b after wait, want 01", k, grant_w);
      end
      req_w = 2'b00;
      tick();
      for (int c = 0; c < 10 && busy_w !== 1'b0; c++) tick();
      n_checks++;
      if (busy_w !== 1'b0 || handovers_w !== 4'(k + 1)) begin
        n_fail++;
        $display("FAIL wrap_count[%0d]: busy=%b handovers=%0d, want 0 %0d", k, busy_w, handovers_w, (k + 1) % 16);
      end
    end
    n_checks++;
    if (handovers_w !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap_zero: handovers=%0d, want 0", handovers_w);
    end
  endtask

  initial begin
    test_reset();
    test_grant_latency();
    test_round_robin();
    test_guard_abort();
    test_force();
    test_async_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
